axi_lite_master: RTL and testbench
==================================

Name: axi_lite_master

Overview:
- Single-outstanding AXI4-Lite initiator. It converts a simple command/response handshake into complete AXI4-Lite write or read transactions.
- It drives the initiator side of the same AXI4-Lite channel set used by the register-slave DUT. AWADDR/AWVALID, WDATA/WVALID, BREADY, ARADDR/ARVALID and RREADY are outputs; the slave-driven signals are inputs.
- Intended as the synthesizable bus master for the register block, e.g. for bridges, on-chip CPUs-lite, and a bench-free bring-up path.

Parameters:
- ADDR_WIDTH, 4, width of AWADDR/ARADDR/cmd_addr.
- DATA_WIDTH, 32, width of WDATA/RDATA/cmd_wdata/rsp_rdata.

Ports:
- ACLK  in  1  clock; everything samples on the rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transaction address.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse; transaction complete.
- rsp_write  out  1  echo of cmd_write for the completed transaction.
- rsp_rdata  out  DATA_WIDTH  captured RDATA; 0 for writes.
- rsp_resp  out  2  captured BRESP or RRESP.
- AWADDR, AWVALID  out  ADDR_WIDTH, 1  write address channel.
- AWREADY  in  1  write address channel ready.
- WDATA, WVALID  out  DATA_WIDTH, 1  write data channel.
- WREADY  in  1  write data channel ready.
- BRESP, BVALID  in  2, 1  write response channel.
- BREADY  out  1  write response ready.
- ARADDR, ARVALID  out  ADDR_WIDTH, 1  read address channel.
- ARREADY  in  1  read address channel ready.
- RDATA, RRESP, RVALID  in  DATA_WIDTH, 2, 1  read data channel.
- RREADY  out  1  read data ready.

Behaviour:
- Reset:
  - Reset is asynchronous and active-low (ARESETn); one clock, ACLK.
  - While ARESETn=0: FSM=IDLE, and all VALID/READY outputs, rsp_valid, rsp_write, rsp_resp, rsp_rdata, AWADDR, WDATA and ARADDR are 0.
  - cmd_ready is 0 during reset and 1 in the first IDLE cycle after release.
- States: IDLE, WRITE, WRESP, RADDR, RDATA.
- Registered outputs: all AXI outputs come from flops, with no combinational path from an input to any VALID output.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid with cmd_write=1: latch addr/data into AWADDR/WDATA, set AWVALID=WVALID=1, go to WRITE.
  - On cmd_valid with cmd_write=0: latch ARADDR, set ARVALID=1, go to RADDR.
  - cmd_ready=0 in every other state.
- WRITE:
  - Track aw_done and w_done independently.
  - AWVALID drops the cycle after AWVALID&&AWREADY; WVALID drops the cycle after WVALID&&WREADY. The two handshakes may complete in the same cycle or in either order.
  - A VALID, once raised, stays high with stable payload until its handshake.
  - When both are done, go to WRESP.
- WRESP:
  - BREADY=1.
  - On BVALID: capture BRESP, drop BREADY, pulse rsp_valid with rsp_write=1 and rsp_rdata=0, return to IDLE.
- RADDR:
  - ARVALID held until ARREADY.
  - On handshake: ARVALID=0, RREADY=1, go to RDATA.
- RDATA:
  - On RVALID&&RREADY: capture RDATA/RRESP, RREADY=0, pulse rsp_valid with rsp_write=0, return to IDLE.
- Response outputs:
  - rsp_valid is high exactly one cycle: the first IDLE cycle after the final handshake. cmd_ready is also 1 in that cycle, so back-to-back commands are legal.
  - rsp_rdata, rsp_resp and rsp_write hold their values until the next response.
- Minimum latency with zero-wait slave:
  - Write: accept at edge 0; AW/W handshake cycle 1; BVALID earliest cycle 2; rsp_valid cycle 3.
  - Read: AR handshake cycle 1; R handshake cycle 2; rsp_valid cycle 3.
- Slave signal handling:
  - BVALID/RVALID arriving outside WRESP/RDATA are ignored, since READY is low.
  - The RESP value is passed through unchanged; no retry on SLVERR/DECERR.
- Reset mid-transaction: outputs clear immediately; no response is generated; the pending command is lost.

Test Plan:
- Zero-wait slave, write addr 0x4 data 0xA5A5_0001 -> AWVALID/WVALID high one cycle; BREADY at cycle 2; rsp_valid at cycle 3 with rsp_write=1, rsp_resp=0.
- AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops after cycle 1; AWVALID held 4 cycles with AWADDR stable; BREADY rises only after the AW handshake.
- Read addr 0x8, slave returns RDATA=0xDEADBEEF after 2 wait cycles -> rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_write=0, single-cycle rsp_valid.
- Write with BRESP=2'b10 -> rsp_resp=2'b10; next read proceeds normally.
- Back-to-back write then read with cmd_valid held high -> second command accepted in the rsp_valid cycle; no idle bubble beyond that.
- ARESETn asserted while in WRITE with AWVALID=1 -> AWVALID/WVALID go 0 asynchronously; no rsp_valid; cmd_ready=1 after release.

Source files
------------

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// Turns a cmd/rsp handshake into one complete AXI4-Lite write or read at a time.
// Every AXI output comes straight from a flop, so no slave input reaches a VALID
// combinationally.
module axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  // Command side
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  // Response side
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  // Write address channel
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  // Write data channel
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  // Write response channel
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  // Read address channel
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  // Read data channel
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRaddr,
    StRdata
  } state_e;

  state_e state_q, state_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  // Next-state and next-output logic; every register holds unless a handshake moves it.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    araddr_d    = araddr_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrite;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = StRaddr;
          end
        end
      end
      StWrite: begin
        // AW and W complete independently; a low VALID here means that half is done.
        awvalid_d = awvalid_q && !AWREADY;
        wvalid_d  = wvalid_q && !WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWresp;
        end
      end
      StWresp: begin
        if (BVALID) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = BRESP;
          state_d     = StIdle;
        end
      end
      StRaddr: begin
        if (ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdata;
        end
      end
      StRdata: begin
        if (RVALID) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = RDATA;
          rsp_resp_d  = RRESP;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so cmd_ready is low throughout reset and rises with the first IDLE cycle.
    cmd_ready_d = (state_d == StIdle);
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      araddr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      araddr_q    <= araddr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign AWADDR    = awaddr_q;
  assign AWVALID   = awvalid_q;
  assign WDATA     = wdata_q;
  assign WVALID    = wvalid_q;
  assign BREADY    = bready_q;
  assign ARADDR    = araddr_q;
  assign ARVALID   = arvalid_q;
  assign RREADY    = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: a behavioural AXI4-Lite slave with programmable
// per-channel wait states, plus a memory/response reference model.
module tb_axi_lite_master;

  logic        ACLK, ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [31:0] WDATA, RDATA;
  logic [1:0]  BRESP, RRESP;

  int vectors = 0;
  int miscompares = 0;

  // Slave wait states, in cycles, applied to the next transaction on each channel
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;

  logic [31:0] slave_mem [16];
  logic [31:0] ref_mem [16];
  logic        aw_seen = 1'b0, w_seen = 1'b0, ar_seen = 1'b0;
  logic [3:0]  aw_addr_got, ar_addr_got;
  logic [31:0] w_data_got;

  axi_lite_master #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Slave response rule: 0xF answers SLVERR, 0xE answers DECERR, all else OKAY
  function automatic logic [1:0] slave_resp(input logic [3:0] a);
    if (a == 4'hF) return 2'b10;
    if (a == 4'hE) return 2'b11;
    return 2'b00;
  endfunction

  // Slave AW channel
  initial begin
    AWREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (AWVALID) begin
        repeat (aw_dly) @(negedge ACLK);
        if (AWVALID) begin
          AWREADY = 1'b1;
          aw_addr_got = AWADDR;
          @(posedge ACLK);
          aw_seen = 1'b1;
          @(negedge ACLK);
          AWREADY = 1'b0;
        end
      end
    end
  end

  // Slave W channel
  initial begin
    WREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (WVALID) begin
        repeat (w_dly) @(negedge ACLK);
        if (WVALID) begin
          WREADY = 1'b1;
          w_data_got = WDATA;
          @(posedge ACLK);
          w_seen = 1'b1;
          @(negedge ACLK);
          WREADY = 1'b0;
        end
      end
    end
  end

  // Slave B channel: commit the write, then respond
  initial begin
    int n;
    BVALID = 1'b0;
    BRESP  = 2'b00;
    forever begin
      @(negedge ACLK);
      if (aw_seen && w_seen) begin
        aw_seen = 1'b0;
        w_seen  = 1'b0;
        slave_mem[aw_addr_got] = w_data_got;
        repeat (b_dly) @(negedge ACLK);
        BVALID = 1'b1;
        BRESP  = slave_resp(aw_addr_got);
        n = 0;
        while (!BREADY && n < 100) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        BVALID = 1'b0;
        BRESP  = 2'($urandom);
      end
    end
  end

  // Slave AR channel
  initial begin
    ARREADY = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARVALID) begin
        repeat (ar_dly) @(negedge ACLK);
        if (ARVALID) begin
          ARREADY = 1'b1;
          ar_addr_got = ARADDR;
          @(posedge ACLK);
          ar_seen = 1'b1;
          @(negedge ACLK);
          ARREADY = 1'b0;
        end
      end
    end
  end

  // Slave R channel
  initial begin
    int n;
    RVALID = 1'b0;
    RDATA  = '0;
    RRESP  = 2'b00;
    forever begin
      @(negedge ACLK);
      if (ar_seen) begin
        ar_seen = 1'b0;
        repeat (r_dly) @(negedge ACLK);
        RVALID = 1'b1;
        RDATA  = slave_mem[ar_addr_got];
        RRESP  = slave_resp(ar_addr_got);
        n = 0;
        while (!RREADY && n < 100) begin @(negedge ACLK); n++; end
        @(negedge ACLK);
        RVALID = 1'b0;
        RDATA  = $urandom;
        RRESP  = 2'($urandom);
      end
    end
  end

  // Present a command at a negedge; returns at the negedge of the cycle after acceptance
  task automatic start_cmd(input logic w, input logic [3:0] a, input logic [31:0] d);
    int n;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 4'($urandom);
    cmd_wdata = $urandom;
  endtask

  // k = 1 at call; returns at the negedge where rsp_valid is seen (or after the bound)
  task automatic wait_rsp(output int k);
    k = 1;
    while (!rsp_valid && k < 200) begin @(negedge ACLK); k++; end
  endtask

  task automatic test_reset();
    ARESETn   = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h1;
    cmd_wdata = 32'h1234_5678;
    repeat (3) @(negedge ACLK);
    vectors++;
    if ({AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, cmd_ready} !== 8'h00)
      begin miscompares++; $display("FAIL reset_ctrl: got %b expected 00000000",
        {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, rsp_write, cmd_ready}); end
    vectors++;
    if ({AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp} !== '0)
      begin miscompares++; $display("FAIL reset_data: got %h expected 0",
        {AWADDR, WDATA, ARADDR, rsp_rdata, rsp_resp}); end
    cmd_valid = 1'b0;
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    vectors++;
    if (cmd_ready !== 1'b1)
      begin miscompares++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_write_zero_wait();
    start_cmd(1'b1, 4'h4, 32'hA5A5_0001);
    ref_mem[4] = 32'hA5A5_0001;
    vectors++;
    if ({AWVALID, WVALID, BREADY, cmd_ready} !== 4'b1100 || {AWADDR, WDATA} !== {4'h4, 32'hA5A5_0001})
      begin miscompares++; $display("FAIL wr0_c1: got %b %h %h expected 1100 4 a5a50001",
        {AWVALID, WVALID, BREADY, cmd_ready}, AWADDR, WDATA); end
    @(negedge ACLK);
    vectors++;
    if ({AWVALID, WVALID, BREADY} !== 3'b001)
      begin miscompares++; $display("FAIL wr0_c2: got %b expected 001", {AWVALID, WVALID, BREADY}); end
    @(negedge ACLK);
    vectors++;
    if ({rsp_valid, rsp_write, rsp_resp, cmd_ready, BREADY} !== 6'b110010 || rsp_rdata !== 32'h0)
      begin miscompares++; $display("FAIL wr0_c3_rsp: got %b %h expected 110010 0",
        {rsp_valid, rsp_write, rsp_resp, cmd_ready, BREADY}, rsp_rdata); end
    @(negedge ACLK);
    vectors++;
    if (rsp_valid !== 1'b0)
      begin miscompares++; $display("FAIL wr0_c4_pulse: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_aw_delay();
    logic [31:0] d;
    int k;
    d = $urandom;
    aw_dly = 3;
    start_cmd(1'b1, 4'h2, d);
    ref_mem[2] = d;
    for (int c = 1; c <= 4; c++) begin
      vectors++;
      if ({AWVALID, WVALID, BREADY} !== {1'b1, c == 1, 1'b0} || AWADDR !== 4'h2)
        begin miscompares++; $display("FAIL awdly_c%0d: got %b addr %h expected %b addr 2",
          c, {AWVALID, WVALID, BREADY}, AWADDR, {1'b1, c == 1, 1'b0}); end
      @(negedge ACLK);
    end
    vectors++;
    if ({AWVALID, WVALID, BREADY} !== 3'b001)
      begin miscompares++; $display("FAIL awdly_c5: got %b expected 001", {AWVALID, WVALID, BREADY}); end
    wait_rsp(k);
    vectors++;
    if (k !== 2 || {rsp_valid, rsp_write, rsp_resp} !== 4'b1100)
      begin miscompares++; $display("FAIL awdly_rsp: got k=%0d %b expected k=2 1100",
        k, {rsp_valid, rsp_write, rsp_resp}); end
    aw_dly = 0;
    @(negedge ACLK);
  endtask

  task automatic test_read_wait();
    int k;
    slave_mem[8] = 32'hDEAD_BEEF;
    ref_mem[8]   = 32'hDEAD_BEEF;
    r_dly = 2;
    start_cmd(1'b0, 4'h8, $urandom);
    vectors++;
    if ({ARVALID, RREADY, AWVALID} !== 3'b100 || ARADDR !== 4'h8)
      begin miscompares++; $display("FAIL rd_c1: got %b addr %h expected 100 addr 8",
        {ARVALID, RREADY, AWVALID}, ARADDR); end
    @(negedge ACLK);
    vectors++;
    if ({ARVALID, RREADY} !== 2'b01)
      begin miscompares++; $display("FAIL rd_c2: got %b expected 01", {ARVALID, RREADY}); end
    wait_rsp(k);
    vectors++;
    if (k !== 4 || {rsp_valid, rsp_write, rsp_resp} !== 4'b1000 || rsp_rdata !== 32'hDEAD_BEEF)
      begin miscompares++; $display("FAIL rd_rsp: got k=%0d %b %h expected k=4 1000 deadbeef",
        k, {rsp_valid, rsp_write, rsp_resp}, rsp_rdata); end
    @(negedge ACLK);
    vectors++;
    if ({rsp_valid, RREADY} !== 2'b00 || rsp_rdata !== 32'hDEAD_BEEF)
      begin miscompares++; $display("FAIL rd_hold: got %b %h expected 00 deadbeef",
        {rsp_valid, RREADY}, rsp_rdata); end
    r_dly = 0;
  endtask

  task automatic test_bresp_err();
    logic [31:0] d;
    int k;
    d = $urandom;
    start_cmd(1'b1, 4'hF, d);
    ref_mem[15] = d;
    wait_rsp(k);
    vectors++;
    if (k !== 3 || {rsp_valid, rsp_write, rsp_resp} !== 4'b1110)
      begin miscompares++; $display("FAIL bresp_err: got k=%0d %b expected k=3 1110",
        k, {rsp_valid, rsp_write, rsp_resp}); end
    @(negedge ACLK);
    start_cmd(1'b0, 4'h4, $urandom);
    wait_rsp(k);
    vectors++;
    if (k !== 3 || {rsp_write, rsp_resp} !== 3'b000 || rsp_rdata !== ref_mem[4])
      begin miscompares++; $display("FAIL bresp_next_rd: got k=%0d %b %h expected k=3 000 %h",
        k, {rsp_write, rsp_resp}, rsp_rdata, ref_mem[4]); end
    @(negedge ACLK);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    int k, n;
    d = $urandom;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 4'h6;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    ref_mem[6] = d;
    cmd_write = 1'b0;
    vectors++;
    if (cmd_ready !== 1'b0)
      begin miscompares++; $display("FAIL b2b_busy: got %b expected 0", cmd_ready); end
    wait_rsp(k);
    vectors++;
    if (k !== 3 || {rsp_valid, rsp_write, cmd_ready} !== 3'b111)
      begin miscompares++; $display("FAIL b2b_wr_rsp: got k=%0d %b expected k=3 111",
        k, {rsp_valid, rsp_write, cmd_ready}); end
    @(negedge ACLK);
    cmd_valid = 1'b0;
    vectors++;
    if ({ARVALID, rsp_valid} !== 2'b10 || ARADDR !== 4'h6)
      begin miscompares++; $display("FAIL b2b_rd_start: got %b addr %h expected 10 addr 6",
        {ARVALID, rsp_valid}, ARADDR); end
    wait_rsp(k);
    vectors++;
    if (k !== 3 || {rsp_write, rsp_resp} !== 3'b000 || rsp_rdata !== d)
      begin miscompares++; $display("FAIL b2b_rd_rsp: got k=%0d %b %h expected k=3 000 %h",
        k, {rsp_write, rsp_resp}, rsp_rdata, d); end
    @(negedge ACLK);
  endtask

  task automatic test_reset_mid_write();
    int seen;
    aw_dly = 8;
    w_dly  = 8;
    start_cmd(1'b1, 4'h3, $urandom);
    @(negedge ACLK);
    vectors++;
    if ({AWVALID, WVALID} !== 2'b11)
      begin miscompares++; $display("FAIL rstmid_pre: got %b expected 11", {AWVALID, WVALID}); end
    #2 ARESETn = 1'b0;
    #1;
    vectors++;
    if ({AWVALID, WVALID, BREADY, rsp_valid, cmd_ready} !== 5'b00000)
      begin miscompares++; $display("FAIL rstmid_async: got %b expected 00000",
        {AWVALID, WVALID, BREADY, rsp_valid, cmd_ready}); end
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1'b1;
    @(negedge ACLK);
    vectors++;
    if (cmd_ready !== 1'b1)
      begin miscompares++; $display("FAIL rstmid_ready: got %b expected 1", cmd_ready); end
    seen = 0;
    repeat (12) begin
      @(negedge ACLK);
      if (rsp_valid === 1'b1 || AWVALID === 1'b1) seen++;
    end
    vectors++;
    if (seen !== 0)
      begin miscompares++; $display("FAIL rstmid_no_rsp: got %0d stray cycles expected 0", seen); end
    aw_dly = 0;
    w_dly  = 0;
  endtask

  task automatic test_random();
    logic        w;
    logic [3:0]  a;
    logic [31:0] d, exp_data;
    int          k, exp_k;
    for (int t = 0; t < 40; t++) begin
      w = 1'($urandom);
      a = 4'($urandom);
      d = $urandom;
      aw_dly = $urandom_range(0, 3);
      w_dly  = $urandom_range(0, 3);
      b_dly  = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      r_dly  = $urandom_range(0, 3);
      // Completion lands one cycle after the slave's last handshake
      exp_k    = w ? 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly : 3 + ar_dly + r_dly;
      exp_data = w ? 32'h0 : ref_mem[a];
      if (w) ref_mem[a] = d;
      start_cmd(w, a, d);
      wait_rsp(k);
      vectors++;
      if (k !== exp_k || rsp_valid !== 1'b1)
        begin miscompares++; $display("FAIL rand%0d_latency: got k=%0d valid=%b expected k=%0d",
          t, k, rsp_valid, exp_k); end
      vectors++;
      if ({rsp_write, rsp_resp, rsp_rdata} !== {w, slave_resp(a), exp_data})
        begin miscompares++; $display("FAIL rand%0d_rsp: got %b %b %h expected %b %b %h", t,
          rsp_write, rsp_resp, rsp_rdata, w, slave_resp(a), exp_data); end
      @(negedge ACLK);
      vectors++;
      if (rsp_valid !== 1'b0)
        begin miscompares++; $display("FAIL rand%0d_pulse: got %b expected 0", t, rsp_valid); end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      slave_mem[i] = '0;
      ref_mem[i]   = '0;
    end
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    test_reset();
    test_write_zero_wait();
    test_aw_delay();
    test_read_wait();
    test_bresp_err();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
